// File: rtl/count_incr_ctrl_pkg.sv
// Shared state encoding and default step width for the count_incr_ctrl iteration controller.
package count_incr_ctrl_pkg;

  localparam int unsigned CountWidthDefault = 4;

  typedef enum logic [1:0] {
    CiIdle = 2'd0,
    CiRun  = 2'd1,
    CiDone = 2'd2
  } ci_state_e;

endpackage

// File: rtl/count_incr.sv
// Combinational +1 of WIDTH bits; wraps modulo 2^WIDTH.
module count_incr #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  always_comb begin
    out_o = in_i + WIDTH'(1);
  end

endmodule

// File: rtl/count_incr_ctrl.sv
// Up-counting step controller for the radix-4 multiplier: issues step indices 0..last, then pulses done.
// Optional abort input enabled by defining COUNT_INCR_ABORT_EN.
module count_incr_ctrl
  import count_incr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CountWidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] last,
  input  logic             stall,
`ifdef COUNT_INCR_ABORT_EN
  input  logic             abort,
`endif
  output logic             step_valid,
  output logic [WIDTH-1:0] step_idx,
  output logic             first,
  output logic             final_step,
  output logic             busy,
  output logic             done
);

  ci_state_e        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] cnt_inc;
  logic             abort_req;

`ifdef COUNT_INCR_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  count_incr #(
    .WIDTH(WIDTH)
  ) u_incr (
    .in_i (cnt_q),
    .out_o(cnt_inc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      CiIdle: begin
        if (start) begin
          state_d = CiRun;
          cnt_d   = '0;
          last_d  = last;
        end
      end
      CiRun: begin
        // Abort wins over both stall and completion.
        if (abort_req) begin
          state_d = CiIdle;
        end else if (!stall) begin
          if (cnt_q == last_q) begin
            state_d = CiDone;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      CiDone:  state_d = CiIdle;
      default: state_d = CiIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CiIdle;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    step_valid = (state_q == CiRun) && !stall;
    step_idx   = cnt_q;
    first      = step_valid && (cnt_q == '0);
    final_step = step_valid && (cnt_q == last_q);
    busy       = (state_q != CiIdle);
    done       = (state_q == CiDone);
  end

endmodule

// File: tb/tb_count_incr_ctrl.sv
// Self-checking bench for count_incr_ctrl: run-level model compared every cycle plus directed literals.
module tb_count_incr_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] last;
  logic         stall;
  logic         abort;
  logic         step_valid;
  logic [W-1:0] step_idx;
  logic         first;
  logic         final_step;
  logic         busy;
  logic         done;

  count_incr_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last      (last),
    .stall     (stall),
`ifdef COUNT_INCR_ABORT_EN
    .abort     (abort),
`endif
    .step_valid(step_valid),
    .step_idx  (step_idx),
    .first     (first),
    .final_step(final_step),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  bit chk_en   = 1'b0;

  // Run-level model: is a run in progress, which step is pending, and is this the done cycle.
  bit m_running = 1'b0;
  bit m_done    = 1'b0;
  int m_idx     = 0;
  int m_last    = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_running = 1'b0;
      m_done    = 1'b0;
      m_idx     = 0;
      m_last    = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_running) begin
      if (start) begin
        m_running = 1'b1;
        m_idx     = 0;
        m_last    = int'(last);
      end
`ifdef COUNT_INCR_ABORT_EN
    end else if (abort) begin
      m_running = 1'b0;
`endif
    end else if (!stall) begin
      if (m_idx == m_last) begin
        m_running = 1'b0;
        m_done    = 1'b1;
      end else begin
        m_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit v;
      v = m_running && !stall;
      check("m_step_valid", int'(step_valid), int'(v));
      check("m_step_idx", int'(step_idx), m_idx);
      check("m_first", int'(first), int'(v && m_idx == 0));
      check("m_final", int'(final_step), int'(v && m_idx == m_last));
      check("m_busy", int'(busy), int'(m_running || m_done));
      check("m_done", int'(done), int'(m_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start     = 1'b1;
    last      = W'(l);
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for done; leaves the bench in the cycle after done.
  task automatic wait_done(input int exp_len, input string nm);
    bit seen = 1'b0;
    int len  = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        len  = cyc - start_cyc;
      end else begin
        tick();
      end
    end
    check(nm, len, exp_len);
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    last  = '0;
    stall = 1'b0;
    abort = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_idx", int'(step_idx), 0);
    check("rst_done", int'(done), 0);
    tick();

    // last=7, no stall: explicit step walk
    do_start(7);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t1_valid", int'(step_valid), 1);
      check("t1_idx", int'(step_idx), k);
      check("t1_first", int'(first), int'(k == 0));
      check("t1_final", int'(final_step), int'(k == 7));
      tick();
    end
    @(negedge clk);
    check("t1_done", int'(done), 1);
    check("t1_done_cyc", cyc - start_cyc, 9);
    tick();
    @(negedge clk);
    check("t1_busy_after", int'(busy), 0);
    check("t1_idx_hold", int'(step_idx), 7);
    tick();

    // last=0: single step with first and final together
    do_start(0);
    @(negedge clk);
    check("t2_first", int'(first), 1);
    check("t2_final", int'(final_step), 1);
    tick();
    @(negedge clk);
    check("t2_done", int'(done), 1);
    tick();
    tick();

    // last=7 with a two-cycle stall at idx 3
    do_start(7);
    tick();
    tick();
    tick();
    stall = 1'b1;
    @(negedge clk);
    check("t3_stall_valid", int'(step_valid), 0);
    check("t3_stall_idx", int'(step_idx), 3);
    tick();
    tick();
    stall = 1'b0;
    wait_done(11, "t3_len");

    // start during RUN is ignored; start right after done is accepted
    do_start(7);
    tick();
    start = 1'b1;
    last  = W'(2);
    tick();
    start = 1'b0;
    wait_done(9, "t4_len_ignored");
    @(negedge clk);
    check("t4_idle_busy", int'(busy), 0);
    tick();
    do_start(2);
    wait_done(4, "t4_len_new");

    // start with stall in IDLE, stall still high in the first RUN cycle
    stall = 1'b1;
    do_start(1);
    @(negedge clk);
    check("t5_first_stalled", int'(step_valid), 0);
    tick();
    stall = 1'b0;
    wait_done(4, "t5_len");

    // full-range run: 16 steps
    do_start(15);
    wait_done(17, "t6_len");

    // reset mid-run at idx 5
    do_start(7);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t7_busy", int'(busy), 0);
    check("t7_idx", int'(step_idx), 0);
    check("t7_done", int'(done), 0);
    for (int k = 0; k < 12; k++) tick();

`ifdef COUNT_INCR_ABORT_EN
    // abort at idx 9 together with stall
    do_start(15);
    for (int k = 0; k < 9; k++) tick();
    abort = 1'b1;
    stall = 1'b1;
    tick();
    abort = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("t8_busy", int'(busy), 0);
    check("t8_valid", int'(step_valid), 0);
    for (int k = 0; k < 20; k++) tick();
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
